// File: rtl/max2831_spi_arb.sv
// MAX2831 register-write arbiter and 3-wire SPI serialiser: AFC words take priority over host
// writes, and an AFC FRAC/INT pair is kept atomic by masking the host until the pair completes.
module max2831_spi_arb #(
    parameter int         CLK_DIV      = 4,
    parameter logic [3:0] ADDR_FRAC    = 4'd4,
    parameter logic [3:0] ADDR_INT     = 4'd3,
    parameter int         LOCK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        afc_req,
    input  logic [13:0] afc_data,
    input  logic        afc_msb_lsb,
    output logic        afc_grant,
    input  logic        host_req,
    input  logic [3:0]  host_addr,
    input  logic [13:0] host_data,
    output logic        host_grant,
    output logic        max2831_ready,
    output logic        spi_csn,
    output logic        spi_sclk,
    output logic        spi_din
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CLK_DIV);
    localparam logic [9:0] LOCK_LAST  = 10'(LOCK_TIMEOUT - 1);
    localparam logic [5:0] NUM_BITS   = 6'd18;

    state_t      state_r;
    logic [7:0]  div_cnt_r;
    logic [5:0]  bit_cnt_r;
    logic [16:0] shreg_r;
    logic        lock_r;
    logic [9:0]  lock_cnt_r;
    logic [17:0] afc_word_s;
    logic [17:0] host_word_s;

    // Form the 18-bit SPI words {data, addr} for both requesters
    always_comb begin
        afc_word_s  = {afc_data, (afc_msb_lsb ? ADDR_FRAC : ADDR_INT)};
        host_word_s = {host_data, host_addr};
    end

    // Arbitration, pair lock and SPI sequencing; all outputs are registered here
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            div_cnt_r     <= 8'd0;
            bit_cnt_r     <= 6'd0;
            shreg_r       <= 17'd0;
            lock_r        <= 1'b0;
            lock_cnt_r    <= 10'd0;
            afc_grant     <= 1'b0;
            host_grant    <= 1'b0;
            max2831_ready <= 1'b1;
            spi_csn       <= 1'b1;
            spi_sclk      <= 1'b0;
            spi_din       <= 1'b0;
        end else begin
            afc_grant  <= 1'b0;
            host_grant <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (afc_req) begin
                        shreg_r       <= afc_word_s[16:0];
                        spi_din       <= afc_word_s[17];
                        spi_csn       <= 1'b0;
                        max2831_ready <= 1'b0;
                        afc_grant     <= 1'b1;
                        div_cnt_r     <= 8'd0;
                        lock_r        <= afc_msb_lsb;
                        lock_cnt_r    <= 10'd0;
                        state_r       <= ST_SETUP;
                    end else if (lock_r) begin
                        // Host stays masked until the INT half arrives or the pair lock times out
                        if (lock_cnt_r == LOCK_LAST) begin
                            lock_r     <= 1'b0;
                            lock_cnt_r <= 10'd0;
                        end else begin
                            lock_cnt_r <= lock_cnt_r + 10'd1;
                        end
                    end else if (host_req) begin
                        shreg_r       <= host_word_s[16:0];
                        spi_din       <= host_word_s[17];
                        spi_csn       <= 1'b0;
                        max2831_ready <= 1'b0;
                        host_grant    <= 1'b1;
                        div_cnt_r     <= 8'd0;
                        state_r       <= ST_SETUP;
                    end else begin
                        div_cnt_r <= 8'd0;
                    end
                end
                ST_SETUP: begin
                    // Includes the grant cycle, so CS_B leads the first SCLK rise by CLK_DIV+1 cycles
                    if (div_cnt_r == SETUP_LAST) begin
                        div_cnt_r <= 8'd0;
                        bit_cnt_r <= 6'd0;
                        spi_sclk  <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_r != DIV_LAST) begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end else begin
                        div_cnt_r <= 8'd0;
                        if (spi_sclk) begin
                            spi_sclk  <= 1'b0;
                            spi_din   <= shreg_r[16];
                            shreg_r   <= {shreg_r[15:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end else if (bit_cnt_r == NUM_BITS) begin
                            state_r <= ST_HOLD;
                        end else begin
                            spi_sclk <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= 8'd0;
                        spi_csn   <= 1'b1;
                        spi_din   <= 1'b0;
                        state_r   <= ST_GAP;
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r     <= 8'd0;
                        max2831_ready <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    div_cnt_r     <= 8'd0;
                    max2831_ready <= 1'b1;
                    spi_csn       <= 1'b1;
                    spi_sclk      <= 1'b0;
                    spi_din       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max2831_spi_arb.sv
// Scoreboard bench for max2831_spi_arb: two instances (CLK_DIV=4 and CLK_DIV=1) share clk/resetn;
// stimulus queues expected grants and SPI words, a negedge monitor decodes the bus and compares.
module tb_max2831_spi_arb;

    typedef struct packed {
        logic        inst;
        logic [17:0] word;
    } wexp_t;

    typedef struct packed {
        logic inst;
        logic afc;
    } gexp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        afc_req0 = 1'b0;
    logic [13:0] afc_data0 = 14'd0;
    logic        afc_msb0 = 1'b0;
    logic [1:0]  h_req = 2'b00;
    logic [3:0]  h_addr0 = 4'd0, h_addr1 = 4'd0;
    logic [13:0] h_data0 = 14'd0, h_data1 = 14'd0;
    logic [1:0]  afc_grant, host_grant, ready, csn, sclk, din;

    wexp_t word_q[$];
    gexp_t grant_q[$];
    int    n_total = 0;
    int    n_pass = 0;

    always #5 clk = ~clk;

    max2831_spi_arb #(.CLK_DIV(4)) dut (
        .clk(clk), .resetn(resetn),
        .afc_req(afc_req0), .afc_data(afc_data0), .afc_msb_lsb(afc_msb0), .afc_grant(afc_grant[0]),
        .host_req(h_req[0]), .host_addr(h_addr0), .host_data(h_data0), .host_grant(host_grant[0]),
        .max2831_ready(ready[0]), .spi_csn(csn[0]), .spi_sclk(sclk[0]), .spi_din(din[0])
    );

    max2831_spi_arb #(.CLK_DIV(1)) dut1 (
        .clk(clk), .resetn(resetn),
        .afc_req(1'b0), .afc_data(14'd0), .afc_msb_lsb(1'b0), .afc_grant(afc_grant[1]),
        .host_req(h_req[1]), .host_addr(h_addr1), .host_data(h_data1), .host_grant(host_grant[1]),
        .max2831_ready(ready[1]), .spi_csn(csn[1]), .spi_sclk(sclk[1]), .spi_din(din[1])
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor state
    logic [17:0] sh[2];
    int          bits[2];
    int          rl[2];
    logic        prev_csn[2], prev_sclk[2], prev_din[2], prev_g[2];
    logic        g_m;
    wexp_t       we_m;
    gexp_t       ge_m;

    initial begin
        for (int i = 0; i < 2; i++) begin
            sh[i] = 18'd0; bits[i] = 0; rl[i] = 0;
            prev_csn[i] = 1'b1; prev_sclk[i] = 1'b0; prev_din[i] = 1'b0; prev_g[i] = 1'b0;
        end
    end

    // Monitor: decodes grants, SPI words and ready-low length on the falling clock edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            g_m = afc_grant[i] | host_grant[i];
            if (!resetn) begin
                bits[i] = 0; rl[i] = 0; sh[i] = 18'd0; g_m = 1'b0;
            end else begin
                if (prev_g[i]) begin
                    chk("grant_pulse", 32'(g_m), 32'd0);
                end else if (g_m) begin
                    if (grant_q.size() == 0) begin
                        chk("grant_unexpected", 32'(grant_q.size()), 32'd1);
                    end else begin
                        ge_m = grant_q.pop_front();
                        chk("grant_src", 32'({i[0], afc_grant[i], host_grant[i]}),
                            32'({ge_m.inst, ge_m.afc, ~ge_m.afc}));
                        chk("grant_ready_low", 32'(ready[i]), 32'd0);
                    end
                end
                if (!csn[i] && sclk[i] && !prev_sclk[i]) begin
                    sh[i] = {sh[i][16:0], din[i]};
                    bits[i]++;
                end else if (sclk[i] && prev_sclk[i]) begin
                    chk("din_stable_high", 32'(din[i]), 32'(prev_din[i]));
                end
                if (!prev_csn[i] && csn[i]) begin
                    if (word_q.size() == 0) begin
                        chk("word_unexpected", 32'(word_q.size()), 32'd1);
                    end else begin
                        we_m = word_q.pop_front();
                        chk("word_inst", 32'(i), 32'(we_m.inst));
                        chk("word_bits", 32'(bits[i]), 32'd18);
                        chk("word_value", 32'(sh[i]), 32'(we_m.word));
                    end
                    bits[i] = 0;
                    sh[i] = 18'd0;
                end
                if (!ready[i]) begin
                    rl[i]++;
                end else if (rl[i] != 0) begin
                    chk("ready_low_len", 32'(rl[i]), (i == 0) ? 32'd157 : 32'd40);
                    rl[i] = 0;
                end
            end
            prev_csn[i] = csn[i]; prev_sclk[i] = sclk[i]; prev_din[i] = din[i]; prev_g[i] = g_m;
        end
    end

    task automatic push_exp(input logic inst, input logic afc, input logic [17:0] w);
        grant_q.push_back('{inst: inst, afc: afc});
        word_q.push_back('{inst: inst, word: w});
    endtask

    task automatic afc_write(input logic [13:0] d, input logic m);
        bit ok = 1'b0;
        @(negedge clk);
        afc_req0 = 1'b1; afc_data0 = d; afc_msb0 = m;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (afc_grant[0]) begin ok = 1'b1; break; end
        end
        afc_req0 = 1'b0;
        chk("afc_grant_wait", 32'(ok), 32'd1);
    endtask

    task automatic host_write(input int inst, input logic [3:0] a, input logic [13:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        if (inst == 0) begin h_addr0 = a; h_data0 = d; end
        else begin h_addr1 = a; h_data1 = d; end
        h_req[inst] = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (host_grant[inst]) begin ok = 1'b1; break; end
        end
        h_req[inst] = 1'b0;
        chk("host_grant_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int inst);
        bit ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (ready[inst]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("wait_idle", 32'(ok), 32'd1);
    endtask

    initial begin : stim
        int idle;
        bit ok;
        repeat (3) @(negedge clk);
        chk("reset_csn", 32'(csn), 32'h3);
        chk("reset_sclk", 32'(sclk), 32'h0);
        chk("reset_din", 32'(din), 32'h0);
        chk("reset_ready", 32'(ready), 32'h3);
        chk("reset_grants", 32'({afc_grant, host_grant}), 32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Plain host write
        push_exp(1'b0, 1'b0, 18'h12345);
        host_write(0, 4'h5, 14'h1234);
        wait_idle(0);

        // AFC FRAC then INT
        push_exp(1'b0, 1'b1, 18'h2AAA4);
        push_exp(1'b0, 1'b1, 18'h0C553);
        afc_write(14'h2AAA, 1'b1);
        repeat (20) @(negedge clk);
        afc_write(14'h0C55, 1'b0);
        wait_idle(0);

        // Simultaneous requests: AFC wins
        push_exp(1'b0, 1'b1, 18'h00013);
        push_exp(1'b0, 1'b0, 18'h3FFF7);
        fork
            afc_write(14'h0001, 1'b0);
            host_write(0, 4'h7, 14'h3FFF);
        join
        wait_idle(0);

        // Host pending inside an AFC pair waits for the INT half
        push_exp(1'b0, 1'b1, 18'h11114);
        push_exp(1'b0, 1'b1, 18'h22223);
        push_exp(1'b0, 1'b0, 18'h0ABC2);
        afc_write(14'h1111, 1'b1);
        wait_idle(0);
        fork
            host_write(0, 4'h2, 14'h0ABC);
            begin
                repeat (20) @(negedge clk);
                afc_write(14'h2222, 1'b0);
            end
        join
        wait_idle(0);

        // Lock timeout: host granted after LOCK_TIMEOUT+1 idle cycles
        push_exp(1'b0, 1'b1, 18'h0F0F4);
        push_exp(1'b0, 1'b0, 18'h00559);
        afc_write(14'h0F0F, 1'b1);
        wait_idle(0);
        h_addr0 = 4'h9; h_data0 = 14'h0055; h_req[0] = 1'b1;
        idle = 1; ok = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (host_grant[0]) begin ok = 1'b1; break; end
            idle++;
        end
        h_req[0] = 1'b0;
        chk("lock_timeout_grant", 32'(ok), 32'd1);
        chk("lock_timeout_idle", 32'(idle), 32'd1024);
        wait_idle(0);

        // Reset in the middle of SHIFT, then a full word
        grant_q.push_back('{inst: 1'b0, afc: 1'b0});
        host_write(0, 4'h1, 14'h3C3C);
        repeat (70) @(negedge clk);
        chk("abort_pre_csn", 32'(csn[0]), 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("abort_csn", 32'(csn[0]), 32'd1);
        chk("abort_sclk", 32'(sclk[0]), 32'd0);
        chk("abort_ready", 32'(ready[0]), 32'd1);
        chk("abort_din", 32'(din[0]), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        push_exp(1'b0, 1'b0, 18'h1357A);
        host_write(0, 4'hA, 14'h1357);
        wait_idle(0);

        // CLK_DIV=1 instance
        push_exp(1'b1, 1'b0, 18'h12345);
        host_write(1, 4'h5, 14'h1234);
        wait_idle(1);

        repeat (5) @(negedge clk);
        chk("word_q_empty", 32'(word_q.size()), 32'd0);
        chk("grant_q_empty", 32'(grant_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
